// File: rtl/memory_bus_ws_if.sv
// CPU-side and bank-side signal bundle for memory_bus_ws.
// The slave modport is the router; the master modport is the CPU plus the banks.
interface memory_bus_ws_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_BANKS  = 4
);
  logic [ADDR_WIDTH-1:0]           address;
  logic [DATA_WIDTH-1:0]           data_in;
  logic                            write_enable;
  logic                            bus_enable;
  logic [DATA_WIDTH-1:0]           data_out;
  logic                            ready;
  logic                            bus_error;
  logic [NUM_BANKS-1:0]            bank_select;
  logic [ADDR_WIDTH-1:0]           bank_address;
  logic [DATA_WIDTH-1:0]           bank_data_in;
  logic                            bank_write_enable;
  logic [NUM_BANKS*DATA_WIDTH-1:0] bank_data_out;
  logic [NUM_BANKS-1:0]            bank_ready;

  modport slave (
    input  address, data_in, write_enable, bus_enable, bank_data_out, bank_ready,
    output data_out, ready, bus_error, bank_select, bank_address, bank_data_in,
           bank_write_enable
  );

  modport master (
    output address, data_in, write_enable, bus_enable, bank_data_out, bank_ready,
    input  data_out, ready, bus_error, bank_select, bank_address, bank_data_in,
           bank_write_enable
  );
endinterface

// File: rtl/memory_bus_ws.sv
// Bank router between the CPU and its memory banks, with per-bank wait states,
// optional bank_ready handshake and a handshake timeout that reports bus_error.
module memory_bus_ws #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int BANK_BITS  = 2,
  parameter int BANK_SHIFT = 13,
  parameter logic [4*(2**BANK_BITS)-1:0] WAIT_STATES    = 16'h1111,
  parameter logic [(2**BANK_BITS)-1:0]   BANK_HANDSHAKE = 4'b0000,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  memory_bus_ws_if.slave    bus
);
  localparam int NUM_BANKS = 2**BANK_BITS;
  localparam logic [7:0] TMO = TIMEOUT[7:0];

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                  state_q;
  logic [BANK_BITS-1:0]    bank_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    we_q;
  logic                    bwe_q;
  logic [NUM_BANKS-1:0]    sel_q;
  logic [3:0]              wait_q;
  logic [7:0]              tmo_q;
  logic [DATA_WIDTH-1:0]   data_out_q;
  logic                    ready_q;
  logic                    err_q;

  logic [BANK_BITS-1:0]    bank_d;
  logic [NUM_BANKS-1:0]    sel_d;
  logic [3:0]              wait_d;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    bank_done;
  logic                    tmo_hit;

  always_comb begin
    bank_d    = bus.address[BANK_SHIFT +: BANK_BITS];
    sel_d     = NUM_BANKS'(1) << bank_d;
    wait_d    = WAIT_STATES[bank_d*4 +: 4];
    rdata     = bus.bank_data_out[bank_q*DATA_WIDTH +: DATA_WIDTH];
    bank_done = !BANK_HANDSHAKE[bank_q] || bus.bank_ready[bank_q];
    // Timeout fires on the cycle the counter would reach TMO; TMO = 0 never fires.
    tmo_hit   = (TMO != 8'd0) && ((tmo_q + 8'd1) == TMO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bank_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      bwe_q      <= 1'b0;
      sel_q      <= '0;
      wait_q     <= '0;
      tmo_q      <= '0;
      data_out_q <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          if (bus.bus_enable) begin
            addr_q  <= bus.address;
            wdata_q <= bus.data_in;
            we_q    <= bus.write_enable;
            bwe_q   <= bus.write_enable;
            bank_q  <= bank_d;
            sel_q   <= sel_d;
            wait_q  <= wait_d;
            tmo_q   <= '0;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (wait_q != 4'd0) begin
            wait_q <= wait_q - 4'd1;
          end else if (bank_done) begin
            if (!we_q) data_out_q <= rdata;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
            sel_q   <= '0;
            bwe_q   <= 1'b0;
            state_q <= DONE;
          end else if (tmo_hit) begin
            if (!we_q) data_out_q <= '1;
            ready_q <= 1'b1;
            err_q   <= 1'b1;
            sel_q   <= '0;
            bwe_q   <= 1'b0;
            state_q <= DONE;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        DONE: begin
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.data_out          = data_out_q;
  assign bus.ready             = ready_q;
  assign bus.bus_error         = err_q;
  assign bus.bank_select       = sel_q;
  assign bus.bank_address      = addr_q;
  assign bus.bank_data_in      = wdata_q;
  assign bus.bank_write_enable = bwe_q;
endmodule

// File: tb/tb_memory_bus_ws.sv
// Scoreboard bench for memory_bus_ws: stimulus pushes expected completions,
// a negedge monitor pops and compares them when ready pulses.
module tb_memory_bus_ws;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t sbq[$];
  logic prev_ready = 1'b0;

  memory_bus_ws_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .NUM_BANKS(4)) bus ();

  memory_bus_ws #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(16),
    .BANK_BITS(2),
    .BANK_SHIFT(13),
    .WAIT_STATES(16'h3120),
    .BANK_HANDSHAKE(4'b0100),
    .TIMEOUT(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.ready === 1'b1) begin
      chk("ready_single_cycle", {31'd0, prev_ready}, 32'd0);
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready actual=1 expected=0 (cyc %0d)", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("data_out", {16'd0, bus.data_out}, {16'd0, e.data});
        chk("bus_error", {31'd0, bus.bus_error}, {31'd0, e.err});
        chk("latency", cyc, e.due);
      end
    end
    prev_ready = (bus.ready === 1'b1);
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] d, input logic we,
                       input int n, input logic [15:0] edata, input logic eerr);
    @(negedge clk);
    bus.address      = a;
    bus.data_in      = d;
    bus.write_enable = we;
    bus.bus_enable   = 1'b1;
    @(posedge clk);
    #1;
    sbq.push_back('{edata, eerr, cyc + 1 + n});
    bus.bus_enable = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && sbq.size() != 0; k++) @(negedge clk);
    chk("drain_pending", sbq.size(), 32'd0);
    sbq.delete();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset                = 1'b1;
    bus.address          = '0;
    bus.data_in          = '0;
    bus.write_enable     = 1'b0;
    bus.bus_enable       = 1'b0;
    bus.bank_ready       = 4'b0000;
    bus.bank_data_out    = {16'hC3C3, 16'hA5A5, 16'h5678, 16'h1234};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, bus.ready}, 32'd0);
    chk("rst_bus_error", {31'd0, bus.bus_error}, 32'd0);
    chk("rst_bank_select", {28'd0, bus.bank_select}, 32'd0);
    chk("rst_data_out", {16'd0, bus.data_out}, 32'd0);
    chk("rst_bank_we", {31'd0, bus.bank_write_enable}, 32'd0);
    reset = 1'b0;

    // 1: read bank 0, zero wait states
    issue(16'h0005, 16'h0000, 1'b0, 0, 16'h1234, 1'b0);
    @(negedge clk);
    chk("t1_bank_select", {28'd0, bus.bank_select}, 32'h1);
    drain();

    // 2: write bank 3, three wait states -> four strobe cycles, data_out held
    issue(16'h6010, 16'hBEEF, 1'b1, 3, 16'h1234, 1'b0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("t2_bank_select", {28'd0, bus.bank_select}, 32'h8);
        chk("t2_bank_data_in", {16'd0, bus.bank_data_in}, 32'hBEEF);
      end
      if (bus.bank_write_enable === 1'b1) cnt++;
    end
    chk("t2_we_cycles", cnt, 32'd4);
    drain();

    // 3: handshake bank 2, bank_ready arrives after two pending cycles
    issue(16'h4000, 16'h0000, 1'b0, 3, 16'hA5A5, 1'b0);
    repeat (3) @(posedge clk);
    #1 bus.bank_ready = 4'b0100;
    drain();
    bus.bank_ready = 4'b0000;

    // 4: handshake timeout with only unselected banks ready, then a normal read
    bus.bank_ready = 4'b1011;
    issue(16'h4002, 16'h0000, 1'b0, 4, 16'hFFFF, 1'b1);
    drain();
    bus.bank_ready = 4'b0000;
    issue(16'h0100, 16'h0000, 1'b0, 0, 16'h1234, 1'b0);
    drain();

    // 5: reset during a bank-3 write
    @(negedge clk);
    bus.address      = 16'h6010;
    bus.data_in      = 16'hCAFE;
    bus.write_enable = 1'b1;
    bus.bus_enable   = 1'b1;
    @(posedge clk);
    #1 bus.bus_enable = 1'b0;
    @(negedge clk);
    chk("t5_we_active", {31'd0, bus.bank_write_enable}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_bank_select", {28'd0, bus.bank_select}, 32'd0);
    chk("t5_bank_we", {31'd0, bus.bank_write_enable}, 32'd0);
    chk("t5_ready", {31'd0, bus.ready}, 32'd0);
    chk("t5_data_out", {16'd0, bus.data_out}, 32'd0);
    chk("t5_bank_address", {16'd0, bus.bank_address}, 32'd0);
    chk("t5_bank_data_in", {16'd0, bus.bank_data_in}, 32'd0);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.bank_write_enable !== 1'b0) cnt++;
    end
    chk("t5_no_strobes", cnt, 32'd0);

    // 6: bus_enable held across two reads; address changes during ACCESS are ignored
    @(negedge clk);
    bus.address      = 16'h0007;
    bus.write_enable = 1'b0;
    bus.bus_enable   = 1'b1;
    @(posedge clk);
    #1;
    sbq.push_back('{16'h1234, 1'b0, cyc + 1});
    bus.address = 16'h2004;
    @(posedge clk);
    @(negedge clk);
    chk("t6_addr_held", {16'd0, bus.bank_address}, 32'h0007);
    @(posedge clk);
    @(posedge clk);
    #1;
    sbq.push_back('{16'h5678, 1'b0, cyc + 3});
    bus.bus_enable = 1'b0;
    @(negedge clk);
    chk("t6_bank_address", {16'd0, bus.bank_address}, 32'h2004);
    chk("t6_bank_select", {28'd0, bus.bank_select}, 32'h2);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
